zap_ram_fifo: RTL

Synchronous first-word-fall-through FIFO that drives both ports of one `zap_ram_simple` instance (1R+1W block RAM) and hides its one-cycle registered read latency behind a two-entry output buffer. It sits between a producer and a consumer in the same clock domain: write-side push, read-side valid/pop. It is intended for prefetch and store buffers. Full throughput is one push and one pop per cycle, sustained.

---
 rtl/zap_ram_fifo.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/zap_ram_fifo.sv
// ---------------------------------------------------------------------------
// zap_ram_fifo: first-word-fall-through FIFO built on a 1R+1W block RAM.
//
// The RAM has a one-cycle registered read. A two-entry output buffer (head
// and skid) hides that latency, so a push and a pop can both happen every
// cycle. Total capacity is DEPTH (RAM) + 2 (buffer).
//
// Ports
//   i_clk       clock, rising edge
//   i_reset     asynchronous active-high reset
//   i_clear     synchronous flush; overrides push/pop in the same cycle
//   i_wr_en     push request
//   i_wr_data   push data
//   o_full      RAM full; a push is dropped
//   i_rd_en     pop the head entry
//   o_rd_data   head entry (registered)
//   o_rd_valid  head entry is valid
//   o_empty     !o_rd_valid
//   o_level     entries held: RAM + in-flight read + output buffer
//
// zap_ram_simple: simple dual-port RAM, registered read data.
// ---------------------------------------------------------------------------

module zap_ram_simple #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

module zap_ram_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_clear,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic                     o_full,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_rd_valid,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             pend_q, pend_d;
  logic             head_v_q, head_v_d;
  logic             skid_v_q, skid_v_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  logic [PW-1:0]    ram_count;
  logic [WIDTH-1:0] ram_rdata;
  logic             full;
  logic             push;
  logic             pop;
  logic             issue;
  logic [2:0]       buf_occ;

  assign ram_count = wptr_q - rptr_q;
  assign full      = (ram_count == PW'(DEPTH));
  assign push      = i_wr_en & ~full;
  assign pop       = i_rd_en & head_v_q;

  // Buffer slots committed after this edge (pend data will land somewhere).
  // Pop implies head_v, so this never underflows.
  assign buf_occ = {2'b00, head_v_q} + {2'b00, skid_v_q} + {2'b00, pend_q}
                 - {2'b00, pop};
  assign issue   = (ram_count != '0) & (buf_occ <= 3'd1);

  zap_ram_simple #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (push & ~i_clear),
    .i_wr_addr (wptr_q[AW-1:0]),
    .i_wr_data (i_wr_data),
    .i_rd_en   (issue & ~i_clear),
    .i_rd_addr (rptr_q[AW-1:0]),
    .o_rd_data (ram_rdata)
  );

  always_comb begin
    head_v_d = head_v_q;
    skid_v_d = skid_v_q;
    head_d   = head_q;
    skid_d   = skid_q;

    // Pop first: skid moves up into head. If skid is empty head data is
    // left as-is so o_rd_data holds its last value.
    if (pop) begin
      head_v_d = skid_v_q;
      skid_v_d = 1'b0;
      if (skid_v_q) head_d = skid_q;
    end

    // Returning RAM data fills the lowest free slot.
    if (pend_q) begin
      if (!head_v_d) begin
        head_v_d = 1'b1;
        head_d   = ram_rdata;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = ram_rdata;
      end
    end

    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, issue};
    pend_d = issue;

    if (i_clear) begin
      head_v_d = 1'b0;
      skid_v_d = 1'b0;
      wptr_d   = '0;
      rptr_d   = '0;
      pend_d   = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      pend_q   <= 1'b0;
      head_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      head_q   <= '0;
      skid_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      pend_q   <= pend_d;
      head_v_q <= head_v_d;
      skid_v_q <= skid_v_d;
      head_q   <= head_d;
      skid_q   <= skid_d;
    end
  end

  assign o_full     = full;
  assign o_rd_data  = head_q;
  assign o_rd_valid = head_v_q;
  assign o_empty    = ~head_v_q;
  assign o_level    = ram_count + PW'(pend_q) + PW'(head_v_q) + PW'(skid_v_q);

  // The issue rule keeps buffer plus in-flight read at two entries or fewer.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_reset)
    !(pend_q && head_v_q && skid_v_q));

endmodule
